// File: rtl/fir_pkg.sv
// Shared definitions for the sequential FIR stage: default widths, the
// controller state encoding and a constant-safe ceil(log2) helper.
package fir_pkg;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_COEFWIDTH = 8;
  localparam int DEF_NTAPS     = 8;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_MAC  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate slice: one product per enabled cycle, added into
// an ACCWIDTH accumulator. sum exposes acc+product so the caller can capture the final tap.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int COEFWIDTH = DEF_COEFWIDTH,
  parameter int ACCWIDTH  = DEF_DATAWIDTH + DEF_COEFWIDTH + clog2(DEF_NTAPS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [DATAWIDTH-1:0] sample,
  input  logic signed [COEFWIDTH-1:0] coef,
  output logic signed [ACCWIDTH-1:0]  sum
);

  localparam int PW = DATAWIDTH + COEFWIDTH;

  logic signed [PW-1:0]       prod;
  logic signed [ACCWIDTH-1:0] acc;

  assign prod = sample * coef;
  // Explicit sign extension keeps the product signed regardless of context width.
  assign sum  = acc + {{(ACCWIDTH-PW){prod[PW-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fir_seq_filter.sv
// Sequential FIR stage on the FIFO read clock: pops a sample when idle, runs
// NTAPS multiply-accumulate cycles and holds the result on a valid/ready port.
module fir_seq_filter
  import fir_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int COEFWIDTH = DEF_COEFWIDTH,
  parameter int NTAPS     = DEF_NTAPS,
  parameter int ACCWIDTH  = DATAWIDTH + COEFWIDTH + clog2(NTAPS)
) (
  input  logic                        iCLK,
  input  logic                        iRSTN,
  input  logic                        iEMPT,
  input  logic signed [DATAWIDTH-1:0] iRDAT,
  output logic                        oRINC,
  input  logic                        iCWE,
  input  logic [clog2(NTAPS)-1:0]     iCADDR,
  input  logic signed [COEFWIDTH-1:0] iCDAT,
  output logic                        oBUSY,
  output logic signed [ACCWIDTH-1:0]  oDOUT,
  output logic                        oDVALID,
  input  logic                        iDREADY
);

  localparam int KW = clog2(NTAPS);

  state_t state, state_nxt;
  logic   pop, mac_en, last_tap;
  logic [KW-1:0] k;
  logic signed [DATAWIDTH-1:0] x [NTAPS];
  logic signed [COEFWIDTH-1:0] h [NTAPS];
  logic signed [ACCWIDTH-1:0]  mac_sum;

  assign last_tap = (k == KW'(NTAPS - 1));

  // WAIT absorbs the first post-reset cycle, where the upstream empty flag is unreliable.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    mac_en    = 1'b0;
    case (state)
      ST_WAIT: state_nxt = ST_IDLE;
      ST_IDLE: begin
        pop = ~iEMPT;
        if (!iEMPT) state_nxt = ST_MAC;
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (last_tap) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (iDREADY) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  assign oRINC = pop & iRSTN;
  assign oBUSY = (state != ST_IDLE);

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state   <= ST_WAIT;
      k       <= '0;
      oDOUT   <= '0;
      oDVALID <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        k <= '0;
      end else if (mac_en) begin
        k <= k + KW'(1);
      end
      if (mac_en && last_tap) begin
        oDOUT   <= mac_sum;
        oDVALID <= 1'b1;
      end else if (state == ST_OUT && iDREADY) begin
        oDVALID <= 1'b0;
      end
    end
  end

  // Coefficients only change while idle so a computation never sees a mixed set.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      for (int i = 0; i < NTAPS; i++) begin
        x[i] <= '0;
        h[i] <= '0;
      end
    end else begin
      if (pop) begin
        x[0] <= iRDAT;
        for (int i = 1; i < NTAPS; i++) x[i] <= x[i-1];
      end
      if (iCWE && state == ST_IDLE) h[iCADDR] <= iCDAT;
    end
  end

  fir_mac #(
    .DATAWIDTH(DATAWIDTH),
    .COEFWIDTH(COEFWIDTH),
    .ACCWIDTH (ACCWIDTH)
  ) u_mac (
    .clk   (iCLK),
    .rst_n (iRSTN),
    .clr   (pop),
    .en    (mac_en),
    .sample(x[k]),
    .coef  (h[k]),
    .sum   (mac_sum)
  );

endmodule

// File: tb/tb_fir_seq_filter.sv
// Scoreboard bench for fir_seq_filter: a queue-backed FIFO model feeds samples and a
// reference delay line predicts every output, compared on each valid/ready handshake.
module tb_fir_seq_filter;

  localparam int NT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              empt;
  logic signed [7:0] rdat;
  logic              rinc;
  logic              cwe;
  logic [2:0]        caddr;
  logic signed [7:0] cdat;
  logic              busy;
  logic signed [18:0] dout;
  logic              dvalid;
  logic              dready;

  int     fifo_q[$];
  longint exp_q[$];
  int     mx[NT];
  int     mh[NT];
  int     pops = 0;
  int     n_compared = 0;
  int     n_mismatched = 0;

  fir_seq_filter dut (
    .iCLK   (clk),
    .iRSTN  (rst_n),
    .iEMPT  (empt),
    .iRDAT  (rdat),
    .oRINC  (rinc),
    .iCWE   (cwe),
    .iCADDR (caddr),
    .iCDAT  (cdat),
    .oBUSY  (busy),
    .oDOUT  (dout),
    .oDVALID(dvalid),
    .iDREADY(dready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
    end
  endtask

  task automatic updateFifo();
    empt = (fifo_q.size() == 0);
    rdat = (fifo_q.size() > 0) ? 8'(fifo_q[0]) : 8'sd0;
  endtask

  task automatic applyStimulus(input int sample);
    fifo_q.push_back(sample);
    updateFifo();
  endtask

  // Reference model: shift the popped sample in and predict the filter sum.
  task automatic popSample();
    int v;
    longint acc;
    v = fifo_q.pop_front();
    pops++;
    for (int i = NT - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = v;
    acc = 0;
    for (int i = 0; i < NT; i++) acc += longint'(mx[i]) * longint'(mh[i]);
    exp_q.push_back(acc);
  endtask

  task automatic tick();
    logic   do_pop, do_hs;
    longint seen;
    @(negedge clk);
    do_pop = rinc;
    do_hs  = dvalid & dready;
    seen   = dout;
    @(posedge clk);
    #1;
    if (do_pop && fifo_q.size() > 0) popSample();
    if (do_hs) begin
      if (exp_q.size() == 0) checkOutput("sb_empty", 0, 1);
      else checkOutput("sb_out", seen, exp_q.pop_front());
    end
    updateFifo();
    #1;
  endtask

  task automatic writeCoef(input int addr, input int val, input bit taken);
    cwe   = 1'b1;
    caddr = 3'(addr);
    cdat  = 8'(val);
    if (taken) mh[addr] = val;
    tick();
    cwe = 1'b0;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    for (int i = 0; i < NT; i++) begin
      mx[i] = 0;
      mh[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic waitPop(input string tag, input int budget);
    int p0, n;
    p0 = pops;
    n  = 0;
    while (pops == p0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_pop"}, pops - p0, 1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_done"}, longint'(busy) + exp_q.size() + fifo_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0, bad;
    longint held;

    rst_n  = 1'b0;
    cwe    = 1'b0;
    caddr  = '0;
    cdat   = '0;
    dready = 1'b1;
    applyReset();
    applyStimulus(3);

    // Reset holds the pop strobe low even with data waiting.
    repeat (3) tick();
    checkOutput("t1_rst_rinc", rinc, 0);
    checkOutput("t1_rst_dvalid", dvalid, 0);
    checkOutput("t1_rst_dout", dout, 0);
    checkOutput("t1_rst_busy", busy, 1);
    rst_n = 1'b1;
    #1;
    checkOutput("t1_wait_rinc", rinc, 0);
    tick();
    checkOutput("t1_idle_rinc", rinc, 1);
    tick();
    checkOutput("t1_first_pop", pops, 1);
    drain("t1", 40);

    // Single-tap identity with back-pressure: latency and hold.
    dready = 1'b0;
    writeCoef(0, 1, 1);
    p0 = pops;
    applyStimulus(5);
    waitPop("t2", 10);
    repeat (7) tick();
    checkOutput("t2_lat_lo", dvalid, 0);
    tick();
    checkOutput("t2_lat_hi", dvalid, 1);
    checkOutput("t2_dout", dout, 5);
    repeat (5) tick();
    checkOutput("t2_hold_dout", dout, 5);
    checkOutput("t2_hold_dvalid", dvalid, 1);
    checkOutput("t2_single_pop", pops - p0, 1);
    dready = 1'b1;
    tick();
    checkOutput("t2_released", dvalid, 0);

    // Impulse through a ramp of coefficients.
    for (int i = 0; i < NT; i++) writeCoef(i, i + 1, 1);
    applyStimulus(1);
    for (int i = 1; i < NT; i++) applyStimulus(0);
    drain("t3", 200);
    checkOutput("t3_last", dout, 8);

    // Full-scale negative operands must not wrap.
    for (int i = 0; i < NT; i++) writeCoef(i, -128, 1);
    for (int i = 0; i < NT; i++) applyStimulus(-128);
    drain("t4a", 200);
    checkOutput("t4_max", dout, 131072);
    applyStimulus(0);
    drain("t4b", 40);
    checkOutput("t4_shift", dout, 114688);

    // Long back-pressure: no pops, stable output, busy.
    dready = 1'b0;
    applyStimulus(10);
    applyStimulus(20);
    applyStimulus(30);
    bad = 0;
    while (!dvalid && bad < 20) begin
      tick();
      bad++;
    end
    checkOutput("t5_valid", dvalid, 1);
    held = dout;
    p0   = pops;
    bad  = 0;
    repeat (20) begin
      tick();
      if (dout != held || !busy || rinc) bad++;
    end
    checkOutput("t5_stall_bad", bad, 0);
    checkOutput("t5_stall_pops", pops - p0, 0);
    dready = 1'b1;
    tick();
    checkOutput("t5_hs_pops", pops - p0, 0);
    checkOutput("t5_rinc_after", rinc, 1);
    tick();
    checkOutput("t5_pop_after", pops - p0, 1);
    drain("t5", 100);

    // Coefficient writes during MAC are ignored.
    writeCoef(0, 2, 1);
    for (int i = 1; i < NT; i++) writeCoef(i, 0, 1);
    applyStimulus(4);
    waitPop("t6a", 10);
    tick();
    tick();
    writeCoef(0, 7, 0);
    drain("t6a", 40);
    checkOutput("t6_old_coef", dout, 8);
    applyStimulus(3);
    drain("t6b", 40);
    checkOutput("t6_next_old", dout, 6);

    // Reset in the middle of MAC drops the result and clears coefficients.
    applyStimulus(9);
    applyStimulus(6);
    waitPop("t6c", 10);
    repeat (3) tick();
    applyReset();
    #1;
    checkOutput("t6_rst_dvalid", dvalid, 0);
    checkOutput("t6_rst_dout", dout, 0);
    checkOutput("t6_rst_rinc", rinc, 0);
    p0 = pops;
    repeat (2) tick();
    checkOutput("t6_rst_nopop", pops - p0, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("t6_wait_rinc", rinc, 0);
    tick();
    checkOutput("t6_idle_rinc", rinc, 1);
    drain("t6c", 40);
    checkOutput("t6_coef_cleared", dout, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/fir_seq_filter.md
Name: fir_seq_filter

Overview:
Sequential configurable FIR stage that sits directly downstream of the read side of the async FIFO and shares the FIFO's read clock domain.
- Pops one sample from the FIFO when the FIFO is non-empty.
- Shifts the sample into an NTAPS-deep delay line.
- Computes the filter output with one multiply-accumulate per cycle.
- Presents the result on a valid/ready output port.
- Coefficients are runtime-writable while the block is idle.

Parameters:
DATAWIDTH, 8, sample width (signed two's complement); matches the FIFO data width.
COEFWIDTH, 8, coefficient width (signed).
NTAPS, 8, number of taps; must be a power of 2 and at least 2.
ACCWIDTH, DATAWIDTH+COEFWIDTH+clog2(NTAPS) (19 with defaults), accumulator and output width.

Ports:
iCLK  in  1  clock; the FIFO read clock.
iRSTN  in  1  reset, asynchronous, active-low.
iEMPT  in  1  FIFO empty flag.
iRDAT  in  DATAWIDTH  FIFO read data; valid whenever iEMPT=0.
oRINC  out  1  FIFO pop strobe, one cycle per sample.
iCWE  in  1  coefficient write enable.
iCADDR  in  clog2(NTAPS)  coefficient index.
iCDAT  in  COEFWIDTH  coefficient value.
oBUSY  out  1  high whenever state is not IDLE.
oDOUT  out  ACCWIDTH  filter output, signed.
oDVALID  out  1  oDOUT valid.
iDREADY  in  1  downstream accepts oDOUT.

Behaviour:
- Reset (iRSTN low, asynchronous): state=WAIT, delay line=0, all coefficients=0, acc=0, tap counter=0, oDOUT=0, oDVALID=0. oRINC is forced to 0 while iRSTN is low.
- Reset mid-operation: any pending result is discarded; no pop is issued.
- States: WAIT, IDLE, MAC, OUT. Encoding is binary, 2 bits.
- WAIT: lasts exactly one cycle after reset release, because the upstream empty flag is not trustworthy in that cycle. oRINC=0. Next state is IDLE.
- IDLE: oRINC = ~iEMPT (combinational, Mealy).
  - If iEMPT=0, at the edge: x[0]<=iRDAT, x[i]<=x[i-1], acc<=0, k<=0, next state MAC.
  - Otherwise stay in IDLE.
- MAC: each edge performs acc<=acc+x[k]*h[k] and k<=k+1.
  - At the edge where k=NTAPS-1: oDOUT<=acc+x[k]*h[k], oDVALID<=1, next state OUT.
  - MAC occupies exactly NTAPS cycles.
- Latency: oDVALID rises NTAPS cycles after the pop edge (8 with defaults).
- OUT: oDOUT and oDVALID are held stable. When iDREADY=1, at the edge: oDVALID<=0, next state IDLE. No pop occurs in the handshake cycle.
- Throughput: at most 1 sample per NTAPS+2 cycles.
- oRINC is 0 in WAIT, MAC and OUT, so the block never pops while busy or back-pressured.
- Coefficient writes:
  - With iCWE=1 and state IDLE, h[iCADDR]<=iCDAT at the edge.
  - Writes are ignored in any other state.
  - A write and a pop in the same IDLE cycle are both performed; the new coefficient is used by that computation.
- Arithmetic:
  - Signed product of DATAWIDTH+COEFWIDTH bits, sign-extended to ACCWIDTH.
  - Overflow is impossible by construction. No rounding and no saturation.
  - The tap counter wraps naturally at NTAPS.

Decomposition:
- Shared package fir_pkg holds:
  - the clog2 function;
  - the state encoding constants ST_WAIT=0, ST_IDLE=1, ST_MAC=2, ST_OUT=3;
  - the default widths.
- Sub-module fir_mac holds the signed multiplier plus accumulator, with clr and en controls and ACCWIDTH output.
- The FSM, delay line, coefficient registers and output register live in fir_seq_filter.

Test Plan:
1. Hold iRSTN=0 with iEMPT=0 -> oRINC=0, oDVALID=0, oDOUT=0. Release iRSTN -> oRINC=0 in the first cycle, then oRINC=1 in the next cycle.
2. Write h[0]=1 and all other taps 0, then present sample 5 -> exactly one oRINC pulse, oDVALID high 8 cycles after the pop edge, oDOUT=5 held until iDREADY.
3. Load h[i]=i+1 (1..8), then feed samples 1,0,0,0,0,0,0,0 with iDREADY=1 -> outputs 1,2,3,4,5,6,7,8.
4. Load all h=-128 and feed eight samples of -128 -> 8th output oDOUT=131072 with no wrap; a 9th sample of 0 -> 114688.
5. Hold iDREADY=0 for 20 cycles with iEMPT=0 -> no oRINC, oDOUT stable, oBUSY=1. Raise iDREADY -> handshake, then one pop 1 cycle later.
6. Issue iCWE to h[0]=7 during MAC -> coefficient unchanged and next output uses the old value. Assert iRSTN=0 mid-MAC -> oDVALID=0, oDOUT=0, coefficients=0, and no pop until 1 cycle after release.
